// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared definitions for the PWM duty-cycle fade controller.
//   - CSR offsets relative to the block's BASE_ADDR
//   - offset of the duty register inside the controlled pwm instance
//   - FSM state encoding
//   - fade_next(): one +/-1 step of the duty value toward the target
package pwm_fade_pkg;

    localparam logic [4:0] CSR_CTRL     = 5'd0;
    localparam logic [4:0] CSR_TARGET   = 5'd1;
    localparam logic [4:0] CSR_STATUS   = 5'd2;
    localparam logic [4:0] PWM_DUTY_OFS = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } fade_state_t;

    // Only called while cur != target, so the result never wraps.
    function automatic logic [6:0] fade_next(input logic [6:0] cur,
                                             input logic [6:0] target);
        return (target > cur) ? cur + 7'd1 : cur - 7'd1;
    endfunction

endpackage

// File: rtl/pwm_fade.sv
// pwm_fade: ramps the 7-bit duty cycle of one pwm instance toward a host
// programmed target, one +/-1 step every (div+1) step_ce pulses. It owns the
// pwm's CSR write port; host traffic always wins and passes straight through.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   csr_a/di/we/re    host CSR bus (csr_re only marks the bus busy here)
//   csr_do            read data for CTRL/TARGET/STATUS, 0 for other addresses
//   step_ce           prescaled one-cycle step-rate strobe
//   pwm_csr_a/di/we   muxed CSR write port toward the pwm instance
//   busy              registered, FSM not in IDLE
//   done              registered one-cycle pulse when a fade reaches target
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no fade; leaves when enabled and cur != target
// WAIT    | counting step_ce pulses up to div
// WRITE   | waiting for a free bus to write the next duty value
module pwm_fade
    import pwm_fade_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter logic [4:0] PWM_BASE  = 5'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    input  logic       csr_re,
    output logic [7:0] csr_do,
    input  logic       step_ce,
    output logic [4:0] pwm_csr_a,
    output logic [7:0] pwm_csr_di,
    output logic       pwm_csr_we,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] ADDR_CTRL   = BASE_ADDR + CSR_CTRL;
    localparam logic [4:0] ADDR_TARGET = BASE_ADDR + CSR_TARGET;
    localparam logic [4:0] ADDR_STATUS = BASE_ADDR + CSR_STATUS;
    localparam logic [4:0] ADDR_DUTY   = PWM_BASE + PWM_DUTY_OFS;

    logic        en_q;
    logic [3:0]  div_q;
    logic [6:0]  target_q;
    logic [6:0]  cur_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    fade_state_t state_q;

    logic        wr_ctrl;
    logic        wr_target;
    logic        wr_duty;
    logic        bus_free;
    logic        en_eff;
    logic [6:0]  next_duty;

    fade_state_t state_n;
    logic [3:0]  cnt_n;
    logic [6:0]  cur_n;
    logic        done_n;
    logic        fade_we;

    assign wr_ctrl   = csr_we && (csr_a == ADDR_CTRL);
    assign wr_target = csr_we && (csr_a == ADDR_TARGET);
    assign wr_duty   = csr_we && (csr_a == ADDR_DUTY);
    assign bus_free  = !csr_we && !csr_re;
    assign next_duty = fade_next(cur_q, target_q);

    // The FSM reacts to the enable value being written in this cycle, so a
    // fade starts on the CTRL write edge and clearing en reaches IDLE on it.
    assign en_eff = wr_ctrl ? csr_di[7] : en_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        fade_we = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_eff && (cur_q != target_q)) begin
                    state_n = ST_WAIT;
                    cnt_n   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (step_ce) begin
                    if (cnt_q == div_q) begin
                        cnt_n   = 4'd0;
                        state_n = ST_WRITE;
                    end else begin
                        cnt_n = cnt_q + 4'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (cur_q == target_q) begin
                    // Target was moved onto cur while we were counting.
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (bus_free) begin
                    fade_we = 1'b1;
                    cnt_n   = 4'd0;
                    if (next_duty == target_q) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase

        // A host duty write resynchronises the fade from the new value; any
        // step that was about to be written is now stale.
        if (wr_duty && (state_q != ST_IDLE)) begin
            state_n = ST_WAIT;
            cnt_n   = 4'd0;
            done_n  = 1'b0;
            fade_we = 1'b0;
        end

        if (!en_eff) begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
            done_n  = 1'b0;
            fade_we = 1'b0;
        end

        if (wr_duty) begin
            cur_n = csr_di[6:0];
        end else if (fade_we) begin
            cur_n = next_duty;
        end else begin
            cur_n = cur_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            div_q    <= 4'd0;
            target_q <= 7'd0;
            cur_q    <= 7'd0;
            cnt_q    <= 4'd0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q  <= csr_di[7];
                div_q <= csr_di[3:0];
            end
            if (wr_target) begin
                target_q <= csr_di[6:0];
            end
            cur_q   <= cur_n;
            cnt_q   <= cnt_n;
            state_q <= state_n;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_n;
        end
    end

    always_comb begin
        pwm_csr_a  = csr_a;
        pwm_csr_di = csr_di;
        pwm_csr_we = csr_we;
        if (fade_we) begin
            pwm_csr_a  = ADDR_DUTY;
            pwm_csr_di = {1'b0, next_duty};
            pwm_csr_we = 1'b1;
        end
        // Reset must also block host writes into the pwm while it is held.
        if (rst) begin
            pwm_csr_we = 1'b0;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (csr_a == ADDR_CTRL) begin
            csr_do = {en_q, 3'b000, div_q};
        end else if (csr_a == ADDR_TARGET) begin
            csr_do = {1'b0, target_q};
        end else if (csr_a == ADDR_STATUS) begin
            csr_do = {busy_q, cur_q};
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_fade.sv
// tb_pwm_fade: directed bench for pwm_fade. Inputs change 1 ns after the
// rising edge; outputs are checked 4 ns after the edge (mid-cycle).
// The pwm instance sits at 0x10 so its duty register (0x11) does not alias
// the fade block's own CSRs at 0x00..0x02.
module tb_pwm_fade;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_TARGET = 5'h01;
    localparam logic [4:0] A_STATUS = 5'h02;
    localparam logic [4:0] A_DUTY   = 5'h11;

    logic       clk;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic       csr_re;
    logic [7:0] csr_do;
    logic       step_ce;
    logic [4:0] pwm_csr_a;
    logic [7:0] pwm_csr_di;
    logic       pwm_csr_we;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    pwm_fade #(.BASE_ADDR(5'h00), .PWM_BASE(5'h10)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_a      (csr_a),
        .csr_di     (csr_di),
        .csr_we     (csr_we),
        .csr_re     (csr_re),
        .csr_do     (csr_do),
        .step_ce    (step_ce),
        .pwm_csr_a  (pwm_csr_a),
        .pwm_csr_di (pwm_csr_di),
        .pwm_csr_we (pwm_csr_we),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    // One bus-free cycle: drive step_ce, check write port, done and busy.
    task automatic cyc(input string tag, input logic sce, input logic ewe,
                       input logic [7:0] edi, input logic edone, input logic ebusy);
        step_ce = sce;
        #3;
        chk({tag, "_we"}, pwm_csr_we, ewe);
        if (ewe) begin
            chk({tag, "_a"}, pwm_csr_a, A_DUTY);
            chk({tag, "_di"}, pwm_csr_di, edi);
        end
        chk({tag, "_done"}, done, edone);
        chk({tag, "_busy"}, busy, ebusy);
        tick();
    endtask

    initial begin
        rst = 1'b1; csr_a = 5'h05; csr_di = 8'hA5; csr_we = 1'b1; csr_re = 1'b0; step_ce = 1'b0;

        // Reset state
        #3;
        chk("rst_pwm_we", pwm_csr_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        csr_we = 1'b0;
        csr_a = A_CTRL;   #1 chk("rst_ctrl", csr_do, 8'h00);
        csr_a = A_TARGET; #1 chk("rst_target", csr_do, 8'h00);
        csr_a = A_STATUS; #1 chk("rst_status", csr_do, 8'h00);
        #12 rst = 1'b0;
        tick();

        // Host write passes through after reset
        csr_a = 5'h07; csr_di = 8'h5A; csr_we = 1'b1;
        #3;
        chk("pass_we", pwm_csr_we, 1'b1);
        chk("pass_a", pwm_csr_a, 5'h07);
        chk("pass_di", pwm_csr_di, 8'h5A);
        csr_we = 1'b0;
        tick();

        // en set with cur == target: stays idle, no done
        step_ce = 1'b1;
        host_wr(A_CTRL, 8'h80);
        for (int k = 1; k <= 3; k++) cyc("en_eq", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Target moved onto cur during WAIT: WRITE exits with done, no write
        host_wr(A_CTRL, 8'h02);
        host_wr(A_TARGET, 8'h03);
        host_wr(A_CTRL, 8'h82);
        cyc("tchg_c1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        host_wr(A_TARGET, 8'h00);
        cyc("tchg_c3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("tchg_c4", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("tchg_c5", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Fade 0 -> 5, div=0, continuous step_ce: writes on cycles 2,4,..,10
        host_wr(A_CTRL, 8'h00);
        host_wr(A_TARGET, 8'h05);
        host_wr(A_CTRL, 8'h80);
        for (int k = 1; k <= 11; k++)
            cyc("f5", 1'b1, (k % 2) == 0, 8'(k / 2), k == 11, k <= 10);
        csr_a = A_STATUS; csr_re = 1'b1;
        #3 chk("f5_status", csr_do, 8'h05);
        tick();
        csr_re = 1'b0;

        // div=3, target 0 -> 2, step_ce every other cycle: writes at 8 and 16
        host_wr(A_CTRL, 8'h03);
        host_wr(A_TARGET, 8'h02);
        host_wr(A_DUTY, 8'h00);
        step_ce = 1'b0;
        host_wr(A_CTRL, 8'h83);
        for (int k = 1; k <= 17; k++)
            cyc("d3", (k % 2) == 1, (k == 8) || (k == 16), (k == 8) ? 8'h01 : 8'h02,
                k == 17, k <= 16);

        // Host read held 3 cycles during WRITE delays the fade write 3 cycles
        host_wr(A_CTRL, 8'h00);
        host_wr(A_TARGET, 8'h04);
        step_ce = 1'b1;
        host_wr(A_CTRL, 8'h80);
        cyc("stall_c1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        csr_a = A_STATUS; csr_re = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            #3;
            chk("stall_we", pwm_csr_we, 1'b0);
            chk("stall_a", pwm_csr_a, A_STATUS);
            chk("stall_rd", csr_do, 8'h82);
            tick();
        end
        csr_re = 1'b0;
        cyc("stall_c5", 1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
        cyc("stall_c6", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("stall_c7", 1'b1, 1'b1, 8'h04, 1'b0, 1'b1);
        cyc("stall_c8", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Host duty write 0x40 during WAIT with target 0x10: fade restarts down
        host_wr(A_CTRL, 8'h00);
        host_wr(A_TARGET, 8'h10);
        host_wr(A_CTRL, 8'h81);
        cyc("hw_c1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        csr_a = A_DUTY; csr_di = 8'h40; csr_we = 1'b1;
        #3;
        chk("hw_pass_we", pwm_csr_we, 1'b1);
        chk("hw_pass_di", pwm_csr_di, 8'h40);
        tick();
        csr_we = 1'b0;
        cyc("hw_c3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("hw_c4", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("hw_c5", 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1);
        cyc("hw_c6", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("hw_c7", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("hw_c8", 1'b1, 1'b1, 8'h3E, 1'b0, 1'b1);
        cyc("hw_c9", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // en cleared mid-fade: idle next cycle, no writes, no done
        host_wr(A_CTRL, 8'h01);
        for (int k = 11; k <= 14; k++) cyc("dis", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        csr_a = A_STATUS;
        #3 chk("dis_status", csr_do, 8'h3E);
        tick();

        // Async reset in the middle of a WRITE cycle
        host_wr(A_CTRL, 8'h80);
        cyc("ar_c1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        #3;
        chk("ar_pre_we", pwm_csr_we, 1'b1);
        chk("ar_pre_di", pwm_csr_di, 8'h3D);
        #1 rst = 1'b1;
        #1;
        chk("ar_we", pwm_csr_we, 1'b0);
        chk("ar_busy", busy, 1'b0);
        csr_a = A_CTRL;   #1 chk("ar_ctrl", csr_do, 8'h00);
        csr_a = A_TARGET; #1 chk("ar_target", csr_do, 8'h00);
        csr_a = A_STATUS; #1 chk("ar_status", csr_do, 8'h00);
        #10 rst = 1'b0;
        tick();
        cyc("ar_after", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        csr_a = A_STATUS;
        #3 chk("ar_status2", csr_do, 8'h00);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
